param_serial_queue: RTL and testbench

PARAM_SERIAL_QUEUE -- requirements
Module: param_serial_queue

---
 rtl/param_serial_queue_pkg.sv | 17 +
 rtl/param_serial_queue_fifo.sv | 64 ++++++
 rtl/param_serial_queue.sv | 142 ++++++++++++++
 tb/tb_param_serial_queue.sv | 353 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/param_serial_queue_pkg.sv
// Shared types and default sizes for the serial-in/serial-out word queue.
package param_serial_queue_pkg;

  typedef enum logic {
    COLLECT = 1'b0,
    HOLD    = 1'b1
  } in_state_t;

  typedef enum logic {
    OUT_IDLE  = 1'b0,
    OUT_SHIFT = 1'b1
  } out_state_t;

  localparam int unsigned DefWidth = 8;
  localparam int unsigned DefDepth = 8;

endpackage

// File: rtl/param_serial_queue_fifo.sv
// Word storage for param_serial_queue: circular buffer with occupancy count.
// A push is accepted while full only when a pop happens on the same edge.
module psq_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wr_data,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign rd_data = mem_q[rd_ptr_q];

  always_comb begin
    do_pop   = pop & ~empty;
    do_push  = push & (~full | do_pop);
    wr_ptr_d = do_push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = do_pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d  = count_q;
    if (do_push && !do_pop) begin
      count_d = count_q + CW'(1);
    end else if (!do_push && do_pop) begin
      count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage contents need no reset; pointers define what is valid.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

endmodule

// File: rtl/param_serial_queue.sv
// Serial deserializer -> word queue -> serializer, both sides MSB-first.
// Optional PSQ_PARITY_EN appends one even-parity bit to every serialized word.
module param_serial_queue
  import param_serial_queue_pkg::*;
#(
  parameter int unsigned WIDTH = DefWidth,
  parameter int unsigned DEPTH = DefDepth
) (
  input  logic                   clock_1MHz,
  input  logic                   rst,
  input  logic                   data_in,
  input  logic                   write_in,
  input  logic                   enqueue_in,
  input  logic                   dequeue_in,
  output logic                   status_out,
  output logic                   data_out,
  output logic                   dout_valid_out,
  output logic                   full_out,
  output logic                   empty_out,
  output logic [$clog2(DEPTH):0] count_out
);

  localparam int unsigned CW = $clog2(WIDTH + 2);

`ifdef PSQ_PARITY_EN
  localparam int unsigned OutBits = WIDTH + 1;
`else
  localparam int unsigned OutBits = WIDTH;
`endif

  in_state_t          in_state_q, in_state_d;
  out_state_t         out_state_q, out_state_d;
  logic [WIDTH-1:0]   in_sr_q, in_sr_d;
  logic [CW-1:0]      in_cnt_q, in_cnt_d;
  logic [OutBits-1:0] out_sr_q, out_sr_d;
  logic [CW-1:0]      out_cnt_q, out_cnt_d;
  logic               started_q;
  logic               push, pop;
  logic [WIDTH-1:0]   rd_data;
  logic [OutBits-1:0] load_word;

`ifdef PSQ_PARITY_EN
  assign load_word = {rd_data, ^rd_data};
`else
  assign load_word = rd_data;
`endif

  psq_fifo #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk    (clock_1MHz),
    .rst    (rst),
    .push   (push),
    .pop    (pop),
    .wr_data(in_sr_q),
    .rd_data(rd_data),
    .full   (full_out),
    .empty  (empty_out),
    .count  (count_out)
  );

  // started_q keeps the deserializer closed until the first edge after reset.
  always_ff @(posedge clock_1MHz or posedge rst) begin
    if (rst) begin
      started_q   <= 1'b0;
      in_state_q  <= COLLECT;
      in_sr_q     <= '0;
      in_cnt_q    <= '0;
      out_state_q <= OUT_IDLE;
      out_sr_q    <= '0;
      out_cnt_q   <= '0;
    end else begin
      started_q   <= 1'b1;
      in_state_q  <= in_state_d;
      in_sr_q     <= in_sr_d;
      in_cnt_q    <= in_cnt_d;
      out_state_q <= out_state_d;
      out_sr_q    <= out_sr_d;
      out_cnt_q   <= out_cnt_d;
    end
  end

  always_comb begin
    in_state_d = in_state_q;
    in_sr_d    = in_sr_q;
    in_cnt_d   = in_cnt_q;
    push       = 1'b0;
    unique case (in_state_q)
      COLLECT: begin
        if (write_in && started_q) begin
          in_sr_d  = {in_sr_q[WIDTH-2:0], data_in};
          in_cnt_d = in_cnt_q + CW'(1);
          if (in_cnt_q == CW'(WIDTH - 1)) begin
            in_state_d = HOLD;
          end
        end
      end
      HOLD: begin
        // A full queue still takes the word if a pop frees a slot this edge.
        if (enqueue_in && (!full_out || pop)) begin
          push       = 1'b1;
          in_cnt_d   = '0;
          in_state_d = COLLECT;
        end
      end
      default: in_state_d = COLLECT;
    endcase
  end

  always_comb begin
    out_state_d = out_state_q;
    out_sr_d    = out_sr_q;
    out_cnt_d   = out_cnt_q;
    pop         = 1'b0;
    unique case (out_state_q)
      OUT_IDLE: begin
        if (dequeue_in && !empty_out) begin
          pop         = 1'b1;
          out_sr_d    = load_word;
          out_cnt_d   = '0;
          out_state_d = OUT_SHIFT;
        end
      end
      OUT_SHIFT: begin
        out_sr_d  = out_sr_q << 1;
        out_cnt_d = out_cnt_q + CW'(1);
        if (out_cnt_q == CW'(OutBits - 1)) begin
          out_state_d = OUT_IDLE;
        end
      end
      default: out_state_d = OUT_IDLE;
    endcase
  end

  always_comb begin
    status_out     = started_q && (in_state_q == COLLECT);
    dout_valid_out = (out_state_q == OUT_SHIFT);
    data_out       = dout_valid_out & out_sr_q[OutBits-1];
  end

endmodule

// File: tb/tb_param_serial_queue.sv
// Self-checking bench for param_serial_queue; expectations come from a word-level queue model.
`timescale 1ns / 1ps
module tb_param_serial_queue;

  localparam int W = 8;
  localparam int D = 8;
`ifdef PSQ_PARITY_EN
  localparam int NBITS = W + 1;
`else
  localparam int NBITS = W;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       data_in, write_in, enqueue_in, dequeue_in;
  logic       status_out, data_out, dout_valid_out, full_out, empty_out;
  logic [3:0] count_out;

  int n_cmp = 0;
  int n_err = 0;
  logic [W-1:0] model_q[$];

  param_serial_queue #(
    .WIDTH(W),
    .DEPTH(D)
  ) dut (
    .clock_1MHz    (clk),
    .rst           (rst),
    .data_in       (data_in),
    .write_in      (write_in),
    .enqueue_in    (enqueue_in),
    .dequeue_in    (dequeue_in),
    .status_out    (status_out),
    .data_out      (data_out),
    .dout_valid_out(dout_valid_out),
    .full_out      (full_out),
    .empty_out     (empty_out),
    .count_out     (count_out)
  );

  always #500 clk = ~clk;

  task automatic tick();
    @(negedge clk);
  endtask

  // Expected serial stream for a word: data MSB-first, then even parity if enabled.
  function automatic logic [63:0] exp_stream(input logic [W-1:0] w);
    logic p;
    p = ($countones(w) % 2) == 1;
    if (NBITS > W) return 64'({w, p});
    return 64'(w);
  endfunction

  task automatic send_word(input logic [W-1:0] w, input bit gaps);
    for (int i = W - 1; i >= 0; i--) begin
      while (gaps && ($urandom_range(0, 3) == 0)) begin
        write_in = 1'b0;
        data_in  = 1'($urandom);
        tick();
      end
      write_in = 1'b1;
      data_in  = w[i];
      tick();
    end
    write_in = 1'b0;
    data_in  = 1'b0;
  endtask

  task automatic enqueue();
    enqueue_in = 1'b1;
    tick();
    enqueue_in = 1'b0;
  endtask

  // Called right after the dequeue edge; gathers bits while valid, bounded.
  task automatic collect_bits(input int extra_deq_at, output logic [63:0] acc, output int n);
    acc = '0;
    n   = 0;
    while (dout_valid_out && n < NBITS + 4) begin
      acc = {acc[62:0], data_out};
      dequeue_in = (n == extra_deq_at);
      n++;
      tick();
    end
    dequeue_in = 1'b0;
  endtask

  task automatic dequeue(output logic [63:0] acc, output int n);
    dequeue_in = 1'b1;
    tick();
    dequeue_in = 1'b0;
    collect_bits(-1, acc, n);
  endtask

  task automatic test_reset();
    rst = 1'b1; data_in = 0; write_in = 0; enqueue_in = 0; dequeue_in = 0;
    tick(); tick();
    n_cmp += 6;
    if (status_out !== 1'b0) begin n_err++; $display("FAIL rst_status got %b want 0", status_out); end
    if (data_out !== 1'b0) begin n_err++; $display("FAIL rst_data got %b want 0", data_out); end
    if (dout_valid_out !== 1'b0) begin n_err++; $display("FAIL rst_valid got %b want 0", dout_valid_out); end
    if (full_out !== 1'b0) begin n_err++; $display("FAIL rst_full got %b want 0", full_out); end
    if (empty_out !== 1'b1) begin n_err++; $display("FAIL rst_empty got %b want 1", empty_out); end
    if (count_out !== 4'd0) begin n_err++; $display("FAIL rst_count got %0d want 0", count_out); end
    rst = 1'b0;
    #1;
    n_cmp++;
    if (status_out !== 1'b0) begin n_err++; $display("FAIL rel_status_pre got %b want 0", status_out); end
    tick();
    n_cmp++;
    if (status_out !== 1'b1) begin n_err++; $display("FAIL rel_status got %b want 1", status_out); end
    model_q.delete();
  endtask

  task automatic test_directed_word();
    logic [63:0] acc;
    int n;
    send_word(8'b1011_0010, 1'b0);
    n_cmp++;
    if (status_out !== 1'b0) begin n_err++; $display("FAIL dir_hold_status got %b want 0", status_out); end
    enqueue();
    model_q.push_back(8'b1011_0010);
    n_cmp += 3;
    if (count_out !== 4'(model_q.size())) begin
      n_err++; $display("FAIL dir_count got %0d want %0d", count_out, model_q.size());
    end
    if (status_out !== 1'b1) begin n_err++; $display("FAIL dir_status got %b want 1", status_out); end
    if (empty_out !== 1'b0) begin n_err++; $display("FAIL dir_empty got %b want 0", empty_out); end
    dequeue(acc, n);
    n_cmp += 4;
    if (n !== NBITS) begin n_err++; $display("FAIL dir_len got %0d want %0d", n, NBITS); end
    if (acc !== exp_stream(model_q[0])) begin
      n_err++; $display("FAIL dir_bits got %h want %h", acc, exp_stream(model_q[0]));
    end
    void'(model_q.pop_front());
    if (empty_out !== 1'b1) begin n_err++; $display("FAIL dir_empty_after got %b want 1", empty_out); end
    if (data_out !== 1'b0) begin n_err++; $display("FAIL dir_idle_data got %b want 0", data_out); end
  endtask

  task automatic test_random_words();
    logic [63:0] acc;
    int n;
    logic [W-1:0] w;
    for (int it = 0; it < 6; it++) begin
      int k = $urandom_range(1, D);
      for (int j = 0; j < k; j++) begin
        w = W'($urandom);
        send_word(w, 1'b1);
        enqueue();
        model_q.push_back(w);
        n_cmp++;
        if (count_out !== 4'(model_q.size())) begin
          n_err++; $display("FAIL rnd_count got %0d want %0d", count_out, model_q.size());
        end
      end
      while (model_q.size() > 0) begin
        dequeue(acc, n);
        n_cmp++;
        if (n !== NBITS || acc !== exp_stream(model_q[0])) begin
          n_err++;
          $display("FAIL rnd_word got %h/%0d want %h/%0d", acc, n, exp_stream(model_q[0]), NBITS);
        end
        void'(model_q.pop_front());
      end
    end
  endtask

  task automatic test_full();
    logic [63:0] acc;
    int n;
    logic [W-1:0] w9;
    for (int j = 0; j < D; j++) begin
      send_word(W'(j), 1'b0);
      enqueue();
      model_q.push_back(W'(j));
    end
    n_cmp += 2;
    if (full_out !== 1'b1) begin n_err++; $display("FAIL full_flag got %b want 1", full_out); end
    if (count_out !== 4'(D)) begin n_err++; $display("FAIL full_count got %0d want %0d", count_out, D); end
    w9 = 8'hC3;
    send_word(w9, 1'b0);
    enqueue();
    n_cmp += 3;
    if (count_out !== 4'(D)) begin n_err++; $display("FAIL full_ign_count got %0d want %0d", count_out, D); end
    if (status_out !== 1'b0) begin n_err++; $display("FAIL full_hold got %b want 0", status_out); end
    if (full_out !== 1'b1) begin n_err++; $display("FAIL full_ign_flag got %b want 1", full_out); end
    enqueue_in = 1'b1;
    dequeue_in = 1'b1;
    tick();
    enqueue_in = 1'b0;
    dequeue_in = 1'b0;
    model_q.push_back(w9);
    n_cmp += 2;
    if (count_out !== 4'(D)) begin n_err++; $display("FAIL full_pp_count got %0d want %0d", count_out, D); end
    if (status_out !== 1'b1) begin n_err++; $display("FAIL full_pp_status got %b want 1", status_out); end
    collect_bits(-1, acc, n);
    n_cmp++;
    if (acc !== exp_stream(model_q[0])) begin
      n_err++; $display("FAIL full_pp_word got %h want %h", acc, exp_stream(model_q[0]));
    end
    void'(model_q.pop_front());
    while (model_q.size() > 0) begin
      dequeue(acc, n);
      n_cmp++;
      if (acc !== exp_stream(model_q[0])) begin
        n_err++; $display("FAIL full_drain got %h want %h", acc, exp_stream(model_q[0]));
      end
      void'(model_q.pop_front());
    end
  endtask

  task automatic test_ignored_dequeue();
    logic [63:0] acc;
    int n;
    logic [W-1:0] a, b;
    dequeue_in = 1'b1;
    tick();
    dequeue_in = 1'b0;
    n_cmp += 3;
    if (count_out !== 4'd0) begin n_err++; $display("FAIL emp_deq_count got %0d want 0", count_out); end
    if (dout_valid_out !== 1'b0) begin n_err++; $display("FAIL emp_deq_valid got %b want 0", dout_valid_out); end
    if (data_out !== 1'b0) begin n_err++; $display("FAIL emp_deq_data got %b want 0", data_out); end
    a = W'($urandom);
    b = W'($urandom);
    send_word(a, 1'b0); enqueue();
    send_word(b, 1'b0); enqueue();
    model_q.push_back(a);
    model_q.push_back(b);
    dequeue_in = 1'b1;
    tick();
    dequeue_in = 1'b0;
    collect_bits(3, acc, n);
    void'(model_q.pop_front());
    n_cmp += 3;
    if (acc !== exp_stream(a) || n !== NBITS) begin
      n_err++; $display("FAIL mid_deq_word got %h/%0d want %h/%0d", acc, n, exp_stream(a), NBITS);
    end
    if (count_out !== 4'(model_q.size())) begin
      n_err++; $display("FAIL mid_deq_count got %0d want %0d", count_out, model_q.size());
    end
    if (dout_valid_out !== 1'b0) begin n_err++; $display("FAIL mid_deq_valid got %b want 0", dout_valid_out); end
    dequeue(acc, n);
    n_cmp++;
    if (acc !== exp_stream(b)) begin n_err++; $display("FAIL mid_deq_next got %h want %h", acc, exp_stream(b)); end
    void'(model_q.pop_front());
  endtask

  task automatic test_ignored_inputs();
    logic [63:0] acc;
    int n;
    logic [W-1:0] w;
    w = W'($urandom);
    // enqueue mid-word and extra bits in HOLD must both be ignored
    for (int i = W - 1; i >= W - 3; i--) begin
      write_in = 1'b1; data_in = w[i]; tick();
    end
    write_in = 1'b0;
    enqueue();
    n_cmp++;
    if (count_out !== 4'd0) begin n_err++; $display("FAIL col_enq_count got %0d want 0", count_out); end
    for (int i = W - 4; i >= 0; i--) begin
      write_in = 1'b1; data_in = w[i]; tick();
    end
    for (int i = 0; i < 3; i++) begin
      write_in = 1'b1; data_in = ~w[0]; tick();
    end
    write_in = 1'b0;
    enqueue();
    dequeue(acc, n);
    n_cmp++;
    if (acc !== exp_stream(w)) begin n_err++; $display("FAIL hold_wr_word got %h want %h", acc, exp_stream(w)); end
  endtask

  task automatic test_reset_mid();
    logic [63:0] acc;
    int n;
    logic [W-1:0] w;
    for (int j = 0; j < 3; j++) begin
      send_word(W'($urandom), 1'b0);
      enqueue();
    end
    w = 8'hFF;
    for (int i = 0; i < 4; i++) begin
      write_in = 1'b1; data_in = 1'b1; tick();
    end
    write_in = 1'b0;
    #100 rst = 1'b1;
    #1;
    n_cmp += 3;
    if (count_out !== 4'd0) begin n_err++; $display("FAIL mid_rst_count got %0d want 0", count_out); end
    if (empty_out !== 1'b1) begin n_err++; $display("FAIL mid_rst_empty got %b want 1", empty_out); end
    if (status_out !== 1'b0) begin n_err++; $display("FAIL mid_rst_status got %b want 0", status_out); end
    tick();
    rst = 1'b0;
    tick();
    model_q.delete();
    n_cmp += 2;
    if (status_out !== 1'b1) begin n_err++; $display("FAIL post_rst_status got %b want 1", status_out); end
    if (count_out !== 4'd0) begin n_err++; $display("FAIL post_rst_count got %0d want 0", count_out); end
    w = 8'h3C;
    send_word(w, 1'b0);
    enqueue();
    dequeue_in = 1'b1;
    tick();
    dequeue_in = 1'b0;
    tick(); tick();
    #100 rst = 1'b1;
    #1;
    n_cmp += 2;
    if (dout_valid_out !== 1'b0) begin n_err++; $display("FAIL shift_rst_valid got %b want 0", dout_valid_out); end
    if (data_out !== 1'b0) begin n_err++; $display("FAIL shift_rst_data got %b want 0", data_out); end
    tick();
    rst = 1'b0;
    tick();
    w = W'($urandom);
    send_word(w, 1'b0);
    enqueue();
    dequeue(acc, n);
    n_cmp++;
    if (acc !== exp_stream(w)) begin n_err++; $display("FAIL post_rst_word got %h want %h", acc, exp_stream(w)); end
  endtask

`ifdef PSQ_PARITY_EN
  task automatic test_parity();
    logic [63:0] acc;
    int n;
    send_word(8'hA5, 1'b0); enqueue(); dequeue(acc, n);
    n_cmp += 2;
    if (n !== 9) begin n_err++; $display("FAIL par_len got %0d want 9", n); end
    if (acc[0] !== 1'b0) begin n_err++; $display("FAIL par_a5 got %b want 0", acc[0]); end
    send_word(8'hA4, 1'b0); enqueue(); dequeue(acc, n);
    n_cmp++;
    if (acc[0] !== 1'b1) begin n_err++; $display("FAIL par_a4 got %b want 1", acc[0]); end
  endtask
`endif

  initial begin
    test_reset();
    test_directed_word();
    test_random_words();
    test_full();
    test_ignored_dequeue();
    test_ignored_inputs();
    test_reset_mid();
`ifdef PSQ_PARITY_EN
    test_parity();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
